// File: rtl/mul_error_stats.sv
// mul_error_stats -- error-distance statistics for an approximate multiplier.
//
// Purpose: consumes paired products from the exact and the approximate 16x16
// multipliers, forms the error distance ED = |p_exact - p_approx| for each
// sample, and accumulates the statistics of a run of N samples. These are the
// saturating ED sum, the largest ED, the count of nonzero EDs and the sample
// count. MED and ER are derived from them off-chip.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   start, n_samples     begin a run of n_samples pairs (taken only when idle)
//   in_valid, in_ready   pair handshake; a pair counts only when both are high
//   p_exact, p_approx    the two products of one sample
//   busy                 a run is in progress (any state other than idle)
//   done                 one-cycle pulse, statistics are final
//   sum_ed, max_ed,      run statistics, held until the next accepted start
//   err_cnt, sample_cnt
//   sat                  sticky, sum_ed clipped at its maximum during this run
//
// The file also holds mul_error_stats_chk, a checker that watches the
// top-level outputs for protocol invariants.

module mul_error_stats_chk #(
  parameter int ACC_W = 48
) (
  input logic             clk,
  input logic             rst_n,
  input logic             in_ready,
  input logic             busy,
  input logic             done,
  input logic             sat,
  input logic [ACC_W-1:0] sum_ed
);

  // A pair may only be taken while a run is active, and never on the done cycle.
  a_ready_busy: assert property (@(posedge clk) disable iff (!rst_n) in_ready |-> busy);
  a_done_ready: assert property (@(posedge clk) disable iff (!rst_n) done |-> !in_ready);

  // done lasts for exactly one cycle.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);

  // Once clipped, the sum stays pinned at full scale until the next run clears it.
  a_sat_sum: assert property (@(posedge clk) disable iff (!rst_n)
                              sat |-> (sum_ed == {ACC_W{1'b1}}));

endmodule

module mul_error_stats #(
  parameter int PW    = 32,
  parameter int CNT_W = 16,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    p_exact,
  input  logic [PW-1:0]    p_approx,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] sum_ed,
  output logic [PW-1:0]    max_ed,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             sat
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Unsigned error distance. Ordering the operands first keeps the result
  // exact over the full PW-bit range, with no sign bit and no wrap.
  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] a,
                                             input logic [PW-1:0] b);
    logic [PW-1:0] d;
    if (a >= b) begin
      d = a - b;
    end else begin
      d = b - a;
    end
    return d;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] n_r;
  logic [CNT_W-1:0] acc_cnt_r;
  logic             start_ok_s;
  logic             ready_s;
  logic             accept_s;
  logic             last_accept_s;

  logic [PW-1:0]    s1_ed_r;
  logic             s1_valid_r;

  logic [ACC_W:0]   sum_ext_s;
  logic [ACC_W-1:0] sum_r;
  logic [PW-1:0]    max_r;
  logic [CNT_W-1:0] err_r;
  logic [CNT_W-1:0] smp_r;
  logic             sat_r;

  // Handshake decode. in_ready depends only on the registered state and the
  // accept count, so it never combinationally follows in_valid.
  always_comb begin
    start_ok_s    = (state_r == ST_IDLE) && start;
    ready_s       = (state_r == ST_RUN) && (acc_cnt_r < n_r);
    accept_s      = ready_s && in_valid;
    last_accept_s = accept_s && ((acc_cnt_r + CNT_W'(1)) == n_r);
  end

  // Next-state logic for the run sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ok_s) begin
          // An empty run skips straight to the done pulse.
          if (n_samples != {CNT_W{1'b0}}) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_DONE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_accept_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      // DRAIN lets stage 2 fold in the last sample before done is raised.
      ST_DRAIN: state_nxt_s = ST_DONE;
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Run length and accept counter. The length is latched only with an accepted
  // start, so a start pulse in the middle of a run cannot change it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_r       <= {CNT_W{1'b0}};
      acc_cnt_r <= {CNT_W{1'b0}};
    end else if (start_ok_s) begin
      n_r       <= n_samples;
      acc_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      acc_cnt_r <= acc_cnt_r + CNT_W'(1);
    end
  end

  // Stage 1: register the error distance of each accepted pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_ed_r    <= {PW{1'b0}};
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_ed_r <= abs_diff(p_exact, p_approx);
      end
    end
  end

  // Widen the ED to ACC_W+1 bits so the carry out of the top bit shows an overflow.
  always_comb begin
    sum_ext_s = {1'b0, sum_r} + {{(ACC_W + 1 - PW){1'b0}}, s1_ed_r};
  end

  // Stage 2: fold the registered ED into the statistics. Stage 1 is always
  // empty while idle, so a start never coincides with an update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r <= {ACC_W{1'b0}};
      max_r <= {PW{1'b0}};
      err_r <= {CNT_W{1'b0}};
      smp_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (start_ok_s) begin
      sum_r <= {ACC_W{1'b0}};
      max_r <= {PW{1'b0}};
      err_r <= {CNT_W{1'b0}};
      smp_r <= {CNT_W{1'b0}};
      sat_r <= 1'b0;
    end else if (s1_valid_r) begin
      if (sum_ext_s[ACC_W]) begin
        sum_r <= {ACC_W{1'b1}};
        sat_r <= 1'b1;
      end else begin
        sum_r <= sum_ext_s[ACC_W-1:0];
      end
      if (s1_ed_r > max_r) begin
        max_r <= s1_ed_r;
      end
      if (s1_ed_r != {PW{1'b0}}) begin
        err_r <= err_r + CNT_W'(1);
      end
      smp_r <= smp_r + CNT_W'(1);
    end
  end

  // All outputs are taken directly from registers or decoded from the state register.
  assign in_ready   = ready_s;
  assign busy       = (state_r != ST_IDLE);
  assign done       = (state_r == ST_DONE);
  assign sum_ed     = sum_r;
  assign max_ed     = max_r;
  assign err_cnt    = err_r;
  assign sample_cnt = smp_r;
  assign sat        = sat_r;

  mul_error_stats_chk #(
    .ACC_W (ACC_W)
  ) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_ready (in_ready),
    .busy     (busy),
    .done     (done),
    .sat      (sat),
    .sum_ed   (sum_ed)
  );

endmodule

// File: tb/tb_mul_error_stats.sv
// Testbench for mul_error_stats. Two instances share every input: one with the
// default 48-bit accumulator and one with a 33-bit accumulator, so that
// saturation can be reached quickly. The expected statistics are computed from
// the list of pairs that the handshake rules say must be accepted.
module tb_mul_error_stats;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] n_samples;
  logic        in_valid;
  logic [31:0] p_exact;
  logic [31:0] p_approx;

  logic        in_ready_a, busy_a, done_a, sat_a;
  logic [47:0] sum_a;
  logic [31:0] max_a;
  logic [15:0] err_a, smp_a;

  logic        in_ready_b, busy_b, done_b, sat_b;
  logic [32:0] sum_b;
  logic [31:0] max_b;
  logic [15:0] err_b, smp_b;

  mul_error_stats dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready_a), .p_exact(p_exact), .p_approx(p_approx),
    .busy(busy_a), .done(done_a), .sum_ed(sum_a), .max_ed(max_a),
    .err_cnt(err_a), .sample_cnt(smp_a), .sat(sat_a)
  );

  mul_error_stats #(.ACC_W(33)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .n_samples(n_samples),
    .in_valid(in_valid), .in_ready(in_ready_b), .p_exact(p_exact), .p_approx(p_approx),
    .busy(busy_b), .done(done_b), .sum_ed(sum_b), .max_ed(max_b),
    .err_cnt(err_b), .sample_cnt(smp_b), .sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  localparam longint unsigned MAX48 = 64'h0000_FFFF_FFFF_FFFF;
  localparam longint unsigned MAX33 = 64'h0000_0001_FFFF_FFFF;

  // Pairs offered in order; entry k is driven until it is accepted.
  logic [31:0]     pa_q[$];
  logic [31:0]     pb_q[$];
  longint unsigned ed_q[$];

  // Observations captured by do_run.
  int          ready_bad, stray_done, timeout;
  logic        obs_done, hold_busy;
  logic [47:0] cap_sum_a, hold_sum_a;
  logic [32:0] cap_sum_b;
  logic [31:0] cap_max_a, cap_max_b;
  logic [15:0] cap_err_a, cap_smp_a, cap_err_b, cap_smp_b, hold_smp_a;
  logic        cap_sat_a, cap_sat_b, hold_sat_b;

  // Reference model results.
  longint unsigned m_raw, m_max, e48, e33;
  int              m_err, m_smp;
  logic            es48, es33;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned absdiff(input logic [31:0] a, input logic [31:0] b);
    longint unsigned x, y;
    x = {32'd0, a};
    y = {32'd0, b};
    return (x > y) ? (x - y) : (y - x);
  endfunction

  // Statistics as defined: plain sums, max and counts, then clipped per accumulator width.
  task automatic model();
    m_raw = 0; m_max = 0; m_err = 0; m_smp = 0;
    foreach (ed_q[i]) begin
      m_raw += ed_q[i];
      if (ed_q[i] > m_max) m_max = ed_q[i];
      if (ed_q[i] != 0) m_err++;
      m_smp++;
    end
    es48 = (m_raw > MAX48);
    e48  = es48 ? MAX48 : m_raw;
    es33 = (m_raw > MAX33);
    e33  = es33 ? MAX33 : m_raw;
  endtask

  // Drives one run. vmode: 0 = in_valid always high, 1 = pattern vpat (LSB first),
  // 2 = random. spur pulses start with a different length during the run.
  task automatic do_run(input int n, input int vmode, input logic [7:0] vpat, input bit spur);
    int acc;
    int cyc;
    bit v;
    acc = 0; cyc = 0;
    ready_bad = 0; stray_done = 0; timeout = 0;
    ed_q.delete();
    start = 1'b1; n_samples = 16'(n);
    tick();
    start = 1'b0;
    while (acc < n && cyc < 200) begin
      if (vmode == 0)      v = 1'b1;
      else if (vmode == 1) v = vpat[cyc % 8];
      else                 v = ($urandom_range(0, 2) != 0);
      in_valid = v;
      p_exact  = v ? pa_q[acc] : $urandom();
      p_approx = v ? pb_q[acc] : $urandom();
      if (spur && cyc == 1) begin
        start = 1'b1; n_samples = 16'(n + 3);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) ready_bad++;
      if (done_a !== 1'b0 || done_b !== 1'b0) stray_done++;
      if (v) begin
        ed_q.push_back(absdiff(pa_q[acc], pb_q[acc]));
        acc++;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    if (acc < n) timeout = 1;
    // Keep offering pairs after the last accept; none of them may be taken.
    in_valid = 1'b1; p_exact = $urandom(); p_approx = $urandom();
    if (n != 0) begin
      @(negedge clk);
      if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) ready_bad++;
      if (done_a !== 1'b0 || done_b !== 1'b0) stray_done++;
      tick();
    end
    // Done cycle; a start here must be ignored.
    start = 1'b1; n_samples = 16'd1;
    @(negedge clk);
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) ready_bad++;
    obs_done  = done_a & done_b;
    cap_sum_a = sum_a; cap_sum_b = sum_b;
    cap_max_a = max_a; cap_max_b = max_b;
    cap_err_a = err_a; cap_err_b = err_b;
    cap_smp_a = smp_a; cap_smp_b = smp_b;
    cap_sat_a = sat_a; cap_sat_b = sat_b;
    tick();
    start = 1'b0;
    @(negedge clk);
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) ready_bad++;
    if (done_a !== 1'b0 || done_b !== 1'b0) stray_done++;
    hold_busy  = busy_a | busy_b;
    hold_sum_a = sum_a; hold_smp_a = smp_a; hold_sat_b = sat_b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({in_ready_a, busy_a, done_a, sat_a, in_ready_b, busy_b, done_b, sat_b} !== 8'd0) begin
      $display("FAIL reset_flags: got %b want 00000000",
               {in_ready_a, busy_a, done_a, sat_a, in_ready_b, busy_b, done_b, sat_b});
    end else n_pass++;
    n_checks++;
    if (sum_a !== 48'd0 || max_a !== 32'd0 || err_a !== 16'd0 || smp_a !== 16'd0 || sum_b !== 33'd0) begin
      $display("FAIL reset_stats: got sum=%0h max=%0h err=%0d smp=%0d want all 0",
               sum_a, max_a, err_a, smp_a);
    end else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    pa_q = '{32'd100, 32'd200, 32'h10, 32'hFFFF_FFFF};
    pb_q = '{32'd100, 32'd196, 32'h18, 32'h0};
    do_run(4, 0, 8'h00, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || stray_done != 0 || timeout != 0 || ready_bad != 0) begin
      $display("FAIL dir_protocol: got done=%b stray=%0d timeout=%0d ready_bad=%0d want 1 0 0 0",
               obs_done, stray_done, timeout, ready_bad);
    end else n_pass++;
    n_checks++;
    if (cap_sum_a !== 48'h1_0000_000B || cap_sum_b !== 33'h1_0000_000B) begin
      $display("FAIL dir_sum: got %0h/%0h want 10000000b", cap_sum_a, cap_sum_b);
    end else n_pass++;
    n_checks++;
    if (cap_max_a !== 32'hFFFF_FFFF || cap_err_a !== 16'd3 || cap_smp_a !== 16'd4) begin
      $display("FAIL dir_max_cnt: got max=%0h err=%0d smp=%0d want ffffffff 3 4",
               cap_max_a, cap_err_a, cap_smp_a);
    end else n_pass++;
    n_checks++;
    if (cap_sat_a !== 1'b0 || cap_sat_b !== 1'b0) begin
      $display("FAIL dir_sat: got %b%b want 00", cap_sat_a, cap_sat_b);
    end else n_pass++;
    n_checks++;
    if (hold_busy !== 1'b0 || hold_sum_a !== 48'h1_0000_000B || hold_smp_a !== 16'd4) begin
      $display("FAIL dir_hold: got busy=%b sum=%0h smp=%0d want 0 10000000b 4",
               hold_busy, hold_sum_a, hold_smp_a);
    end else n_pass++;
  endtask

  task automatic test_zero_len();
    pa_q.delete(); pb_q.delete();
    do_run(0, 0, 8'h00, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || ready_bad != 0 || stray_done != 0 || hold_busy !== 1'b0) begin
      $display("FAIL zero_protocol: got done=%b ready_bad=%0d stray=%0d busy=%b want 1 0 0 0",
               obs_done, ready_bad, stray_done, hold_busy);
    end else n_pass++;
    n_checks++;
    if (cap_sum_a !== 48'd0 || cap_max_a !== 32'd0 || cap_err_a !== 16'd0 ||
        cap_smp_a !== 16'd0 || cap_sat_a !== 1'b0) begin
      $display("FAIL zero_stats: got sum=%0h max=%0h err=%0d smp=%0d sat=%b want all 0",
               cap_sum_a, cap_max_a, cap_err_a, cap_smp_a, cap_sat_a);
    end else n_pass++;
  endtask

  task automatic test_gaps();
    pa_q = '{32'd11, 32'd20, 32'd30};
    pb_q = '{32'd10, 32'd21, 32'd29};
    do_run(3, 1, 8'b1110_1001, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || ready_bad != 0 || stray_done != 0 || timeout != 0) begin
      $display("FAIL gap_protocol: got done=%b ready_bad=%0d stray=%0d timeout=%0d want 1 0 0 0",
               obs_done, ready_bad, stray_done, timeout);
    end else n_pass++;
    n_checks++;
    if (cap_sum_a !== 48'd3 || cap_smp_a !== 16'd3 || cap_err_a !== 16'd3 || cap_max_a !== 32'd1) begin
      $display("FAIL gap_stats: got sum=%0h smp=%0d err=%0d max=%0h want 3 3 3 1",
               cap_sum_a, cap_smp_a, cap_err_a, cap_max_a);
    end else n_pass++;
  endtask

  task automatic test_saturate();
    pa_q = '{32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
    pb_q = '{32'h0, 32'hFFFF_FFFF, 32'h0};
    do_run(3, 0, 8'h00, 1'b0);
    n_checks++;
    if (cap_sum_b !== 33'h1_FFFF_FFFF || cap_sat_b !== 1'b1 || cap_max_b !== 32'hFFFF_FFFF) begin
      $display("FAIL sat33: got sum=%0h sat=%b max=%0h want 1ffffffff 1 ffffffff",
               cap_sum_b, cap_sat_b, cap_max_b);
    end else n_pass++;
    n_checks++;
    if (cap_sum_a !== 48'h2_FFFF_FFFD || cap_sat_a !== 1'b0) begin
      $display("FAIL sat48: got sum=%0h sat=%b want 2fffffffd 0", cap_sum_a, cap_sat_a);
    end else n_pass++;
    n_checks++;
    if (hold_sat_b !== 1'b1 || obs_done !== 1'b1) begin
      $display("FAIL sat_hold: got sat=%b done=%b want 1 1", hold_sat_b, obs_done);
    end else n_pass++;
  endtask

  task automatic test_abort_reset();
    int dn;
    dn = 0;
    start = 1'b1; n_samples = 16'd5;
    tick();
    start = 1'b0;
    in_valid = 1'b1; p_exact = 32'd50; p_approx = 32'd40;
    tick();
    p_exact = 32'd9; p_approx = 32'd1;
    tick();
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    n_checks++;
    if ({in_ready_a, busy_a, done_a, sat_a} !== 4'd0 || sum_a !== 48'd0 || max_a !== 32'd0 ||
        err_a !== 16'd0 || smp_a !== 16'd0 || busy_b !== 1'b0 || sum_b !== 33'd0) begin
      $display("FAIL abort_zero: got flags=%b sum=%0h max=%0h err=%0d smp=%0d want all 0",
               {in_ready_a, busy_a, done_a, sat_a}, sum_a, max_a, err_a, smp_a);
    end else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_a || done_b) dn++;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done_a || done_b || busy_a) dn++;
      tick();
    end
    n_checks++;
    if (dn != 0) begin
      $display("FAIL abort_no_done: got %0d cycles with done/busy want 0", dn);
    end else n_pass++;
    pa_q = '{32'd7};
    pb_q = '{32'd3};
    do_run(1, 0, 8'h00, 1'b0);
    n_checks++;
    if (obs_done !== 1'b1 || cap_sum_a !== 48'd4 || cap_smp_a !== 16'd1 || cap_sum_b !== 33'd4) begin
      $display("FAIL abort_rerun: got done=%b sum=%0h smp=%0d want 1 4 1",
               obs_done, cap_sum_a, cap_smp_a);
    end else n_pass++;
  endtask

  task automatic test_spurious_start();
    pa_q = '{32'd5, 32'd8, 32'd8, 32'd1000};
    pb_q = '{32'd6, 32'd8, 32'd2, 32'd1};
    do_run(4, 0, 8'h00, 1'b1);
    n_checks++;
    if (obs_done !== 1'b1 || ready_bad != 0 || stray_done != 0) begin
      $display("FAIL spur_protocol: got done=%b ready_bad=%0d stray=%0d want 1 0 0",
               obs_done, ready_bad, stray_done);
    end else n_pass++;
    n_checks++;
    if (cap_smp_a !== 16'd4 || cap_sum_a !== 48'd1006 || cap_err_a !== 16'd3 || cap_max_a !== 32'd999) begin
      $display("FAIL spur_stats: got smp=%0d sum=%0d err=%0d max=%0d want 4 1006 3 999",
               cap_smp_a, cap_sum_a, cap_err_a, cap_max_a);
    end else n_pass++;
  endtask

  // Back-to-back random runs compared against the reference model.
  task automatic test_random();
    int n;
    logic [31:0] a;
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 10);
      pa_q.delete(); pb_q.delete();
      for (int k = 0; k < n; k++) begin
        a = $urandom();
        pa_q.push_back(a);
        if ($urandom_range(0, 3) == 0)      pb_q.push_back(a);
        else if ($urandom_range(0, 1) == 0) pb_q.push_back(a ^ 32'($urandom_range(1, 255)));
        else                                pb_q.push_back($urandom());
      end
      do_run(n, 2, 8'h00, 1'b0);
      model();
      n_checks++;
      if (obs_done !== 1'b1 || ready_bad != 0 || stray_done != 0 || timeout != 0 || hold_busy !== 1'b0) begin
        $display("FAIL rnd%0d_protocol: got done=%b ready_bad=%0d stray=%0d timeout=%0d busy=%b",
                 r, obs_done, ready_bad, stray_done, timeout, hold_busy);
      end else n_pass++;
      n_checks++;
      if (cap_sum_a !== e48[47:0] || cap_sat_a !== es48) begin
        $display("FAIL rnd%0d_sum48: got %0h sat=%b want %0h sat=%b", r, cap_sum_a, cap_sat_a, e48, es48);
      end else n_pass++;
      n_checks++;
      if (cap_sum_b !== e33[32:0] || cap_sat_b !== es33) begin
        $display("FAIL rnd%0d_sum33: got %0h sat=%b want %0h sat=%b", r, cap_sum_b, cap_sat_b, e33, es33);
      end else n_pass++;
      n_checks++;
      if (cap_max_a !== m_max[31:0] || cap_max_b !== m_max[31:0] || cap_err_a !== 16'(m_err) ||
          cap_err_b !== 16'(m_err) || cap_smp_a !== 16'(m_smp) || cap_smp_b !== 16'(m_smp)) begin
        $display("FAIL rnd%0d_cnt: got max=%0h err=%0d smp=%0d want %0h %0d %0d",
                 r, cap_max_a, cap_err_a, cap_smp_a, m_max, m_err, m_smp);
      end else n_pass++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; n_samples = 16'd0;
    in_valid = 1'b0; p_exact = 32'd0; p_approx = 32'd0;
    test_reset();
    test_directed();
    test_zero_len();
    test_gaps();
    test_saturate();
    test_abort_reset();
    test_spurious_start();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
